// File: rtl/ifetch_bht.sv
// Instruction-fetch stage: PC register, static 16-bit branch decode,
// 2-bit saturating BHT, stall-tolerant redirect buffer and
// saturating branch / mispredict statistics.
module ifetch_bht #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned BHT_DEPTH = 256,
  parameter logic [1:0]  BHT_INIT  = 2'b10,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             stall_i,
  input  logic [15:0]      instr_i,
  input  logic             jr_i,
  input  logic [PC_W-1:0]  jr_addr_i,
  input  logic             res_valid_i,
  input  logic [PC_W-1:0]  res_pc_i,
  input  logic             res_taken_i,
  input  logic             res_mispredict_i,
  input  logic [PC_W-1:0]  res_target_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [PC_W-1:0]  pcplus1_o,
  output logic             is_branch_o,
  output logic             pred_taken_o,
  output logic [PC_W-1:0]  epc_o,
  output logic [CNT_W-1:0] stat_branches_o,
  output logic [CNT_W-1:0] stat_mispred_o
);

  localparam int unsigned IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_UNCOND,
    BR_COND
  } br_kind_e;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  prev_pc_q, prev_pc_d;
  logic [PC_W-1:0]  pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             boot_q, boot_d;
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [CNT_W-1:0] stat_br_q, stat_br_d;
  logic [CNT_W-1:0] stat_mp_q, stat_mp_d;

  br_kind_e         br_kind;
  logic [PC_W-1:0]  br_imm;
  logic [PC_W-1:0]  br_target;
  logic [1:0]       bht_rd;
  logic             pred_taken;
  logic             mispred;
  logic             redir_v;
  logic [PC_W-1:0]  redir_tgt;
  logic [IDX_W-1:0] res_idx;
  logic [1:0]       bht_cur;
  logic [1:0]       bht_upd;

  // Static decode of the branch encodings and sign-extended immediate.
  always_comb begin
    br_kind = BR_NONE;
    br_imm  = '0;
    unique case (instr_i[15:11])
      5'b00010: begin
        br_kind = BR_UNCOND;
        br_imm  = {{(PC_W-11){instr_i[10]}}, instr_i[10:0]};
      end
      5'b00100, 5'b00101: begin
        br_kind = BR_COND;
        br_imm  = {{(PC_W-8){instr_i[7]}}, instr_i[7:0]};
      end
      5'b01100: begin
        if (instr_i[10:9] == 2'b00) begin
          br_kind = BR_COND;
          br_imm  = {{(PC_W-8){instr_i[7]}}, instr_i[7:0]};
        end
      end
      default: ;
    endcase
  end

  // Prediction lookup (no bypass from a same-cycle update) and redirect selection.
  always_comb begin
    bht_rd     = bht_q[pc_q[IDX_W-1:0]];
    br_target  = pc_q + PC_W'(1) + br_imm;
    pred_taken = (br_kind == BR_UNCOND) || ((br_kind == BR_COND) && bht_rd[1]);
    mispred    = res_valid_i && res_mispredict_i;
    redir_v    = jr_i || mispred;
    if (jr_i)
      redir_tgt = jr_addr_i;
    else if (res_taken_i)
      redir_tgt = res_target_i;
    else
      redir_tgt = res_pc_i + PC_W'(1);
  end

  // Next PC, redirect buffer and boot flag.
  // The boot edge behaves like a stall for redirects: they are parked in the
  // pending register and pc stays at 0, only the boot flag clears.
  always_comb begin
    pc_d      = pc_q;
    prev_pc_d = prev_pc_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    boot_d    = boot_q;
    if (stall_i || boot_q) begin
      if (redir_v) begin
        pend_v_d = 1'b1;
        pend_d   = redir_tgt;
      end
      if (!stall_i) begin
        boot_d    = 1'b0;
        prev_pc_d = pc_q;
      end
    end else begin
      prev_pc_d = pc_q;
      pend_v_d  = 1'b0;
      if (redir_v)
        pc_d = redir_tgt;
      else if (pend_v_q)
        pc_d = pend_q;
      else if (pred_taken)
        pc_d = br_target;
      else
        pc_d = pc_q + PC_W'(1);
    end
  end

  // BHT training value: 2-bit saturating up/down counter.
  always_comb begin
    res_idx = res_pc_i[IDX_W-1:0];
    bht_cur = bht_q[res_idx];
    bht_upd = bht_cur;
    if (res_taken_i) begin
      if (bht_cur != 2'b11) bht_upd = bht_cur + 2'b01;
    end else begin
      if (bht_cur != 2'b00) bht_upd = bht_cur - 2'b01;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (res_valid_i && (stat_br_q != '1)) stat_br_d = stat_br_q + CNT_W'(1);
    if (mispred && (stat_mp_q != '1))     stat_mp_d = stat_mp_q + CNT_W'(1);
  end

  // Fetch-control state registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q      <= '0;
      prev_pc_q <= '0;
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
      boot_q    <= 1'b1;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      pc_q      <= pc_d;
      prev_pc_q <= prev_pc_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
      boot_q    <= boot_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  // BHT storage; trained on every resolution regardless of stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_INIT;
    end else if (res_valid_i) begin
      bht_q[res_idx] <= bht_upd;
    end
  end

  // Output drive.
  always_comb begin
    pc_o            = pc_q;
    pcplus1_o       = pc_q + PC_W'(1);
    is_branch_o     = (br_kind != BR_NONE);
    pred_taken_o    = pred_taken;
    stat_branches_o = stat_br_q;
    stat_mispred_o  = stat_mp_q;
    if (mispred)
      epc_o = res_pc_i;
    else if (jr_i)
      epc_o = prev_pc_q;
    else
      epc_o = pc_q;
  end

endmodule

// File: tb/tb_ifetch_bht.sv
module tb_ifetch_bht;
  localparam int PC_W = 16;

  logic            CLK = 1'b0;
  logic            RST;
  logic            stall_i;
  logic [15:0]     instr_i;
  logic            jr_i;
  logic [PC_W-1:0] jr_addr_i;
  logic            res_valid_i;
  logic [PC_W-1:0] res_pc_i;
  logic            res_taken_i;
  logic            res_mispredict_i;
  logic [PC_W-1:0] res_target_i;

  logic [PC_W-1:0] pc_o, pcplus1_o, epc_o;
  logic            is_branch_o, pred_taken_o;
  logic [31:0]     stat_branches_o, stat_mispred_o;

  logic [PC_W-1:0] pc4, pcp4, epc4;
  logic            isb4, pt4;
  logic [3:0]      sb4, sm4;

  int passed = 0;
  int total  = 0;
  logic [PC_W-1:0] exp_q [$];
  logic [PC_W-1:0] e;

  ifetch_bht #(.PC_W(16), .BHT_DEPTH(256), .BHT_INIT(2'b10), .CNT_W(32)) u_dut (
    .CLK(CLK), .RST(RST), .stall_i(stall_i), .instr_i(instr_i),
    .jr_i(jr_i), .jr_addr_i(jr_addr_i), .res_valid_i(res_valid_i),
    .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
    .res_mispredict_i(res_mispredict_i), .res_target_i(res_target_i),
    .pc_o(pc_o), .pcplus1_o(pcplus1_o), .is_branch_o(is_branch_o),
    .pred_taken_o(pred_taken_o), .epc_o(epc_o),
    .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
  );

  ifetch_bht #(.PC_W(16), .BHT_DEPTH(256), .BHT_INIT(2'b10), .CNT_W(4)) u_dut4 (
    .CLK(CLK), .RST(RST), .stall_i(stall_i), .instr_i(instr_i),
    .jr_i(jr_i), .jr_addr_i(jr_addr_i), .res_valid_i(res_valid_i),
    .res_pc_i(res_pc_i), .res_taken_i(res_taken_i),
    .res_mispredict_i(res_mispredict_i), .res_target_i(res_target_i),
    .pc_o(pc4), .pcplus1_o(pcp4), .is_branch_o(isb4),
    .pred_taken_o(pt4), .epc_o(epc4),
    .stat_branches_o(sb4), .stat_mispred_o(sm4)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    stall_i = 0; instr_i = 16'h0000; jr_i = 0; jr_addr_i = '0;
    res_valid_i = 0; res_pc_i = '0; res_taken_i = 0;
    res_mispredict_i = 0; res_target_i = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1;
    #1;
    total++; if (pc_o !== 16'h0) $display("FAIL rst_pc: got %0h want 0", pc_o); else passed++;
    total++; if (pcplus1_o !== 16'h1) $display("FAIL rst_pcplus1: got %0h want 1", pcplus1_o); else passed++;
    total++; if (stat_branches_o !== 32'd0 || stat_mispred_o !== 32'd0)
      $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_branches_o, stat_mispred_o); else passed++;
    // decode checks at pc 0 (BHT at init value, weakly taken)
    instr_i = 16'h6100; #1;
    total++; if (is_branch_o !== 1'b1 || pred_taken_o !== 1'b1)
      $display("FAIL dec_btnez: got %b%b want 11", is_branch_o, pred_taken_o); else passed++;
    instr_i = 16'h6200; #1;
    total++; if (is_branch_o !== 1'b0 || pred_taken_o !== 1'b0)
      $display("FAIL dec_nonbr: got %b%b want 00", is_branch_o, pred_taken_o); else passed++;
    instr_i = 16'h2800; #1;
    total++; if (is_branch_o !== 1'b1) $display("FAIL dec_bnez: got %b want 1", is_branch_o); else passed++;
    instr_i = 16'h0000;
    tick(); tick();
    RST = 0;
    exp_q.push_back(16'h0); exp_q.push_back(16'h1);
    exp_q.push_back(16'h2); exp_q.push_back(16'h3);
    repeat (4) begin
      tick();
      e = exp_q.pop_front();
      total++; if (pc_o !== e) $display("FAIL boot_seq: got %0h want %0h", pc_o, e); else passed++;
    end
    total++; if (stat_branches_o !== 32'd0) $display("FAIL boot_stats: got %0d want 0", stat_branches_o); else passed++;
  endtask

  task automatic test_branch_bht();
    exp_q.push_back(16'h4); exp_q.push_back(16'h5);
    repeat (2) begin
      tick(); e = exp_q.pop_front();
      total++; if (pc_o !== e) $display("FAIL seq_to5: got %0h want %0h", pc_o, e); else passed++;
    end
    instr_i = 16'h20FC; #1;
    total++; if (is_branch_o !== 1'b1 || pred_taken_o !== 1'b1)
      $display("FAIL beqz_pred_init: got %b%b want 11", is_branch_o, pred_taken_o); else passed++;
    exp_q.push_back(16'h2);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL beqz_taken_pc: got %0h want %0h", pc_o, e); else passed++;
    instr_i = 16'h0000;
    res_valid_i = 1; res_pc_i = 16'h5; res_taken_i = 0; res_mispredict_i = 0;
    exp_q.push_back(16'h3); exp_q.push_back(16'h4);
    repeat (2) begin
      tick(); e = exp_q.pop_front();
      total++; if (pc_o !== e) $display("FAIL train_seq: got %0h want %0h", pc_o, e); else passed++;
    end
    res_valid_i = 0;
    exp_q.push_back(16'h5);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL back_to5: got %0h want %0h", pc_o, e); else passed++;
    instr_i = 16'h20FC; #1;
    total++; if (is_branch_o !== 1'b1 || pred_taken_o !== 1'b0)
      $display("FAIL beqz_pred_trained: got %b%b want 10", is_branch_o, pred_taken_o); else passed++;
    exp_q.push_back(16'h6);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL beqz_nt_pc: got %0h want %0h", pc_o, e); else passed++;
    instr_i = 16'h0000;
    total++; if (stat_branches_o !== 32'd2 || stat_mispred_o !== 32'd0)
      $display("FAIL stats_after_train: got %0d/%0d want 2/0", stat_branches_o, stat_mispred_o); else passed++;
  endtask

  task automatic test_uncond();
    jr_i = 1; jr_addr_i = 16'h10; #1;
    total++; if (epc_o !== 16'h5) $display("FAIL jr_epc: got %0h want 5", epc_o); else passed++;
    exp_q.push_back(16'h10);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL jr_pc: got %0h want %0h", pc_o, e); else passed++;
    jr_i = 0;
    instr_i = 16'h17FF; #1;
    total++; if (is_branch_o !== 1'b1 || pred_taken_o !== 1'b1)
      $display("FAIL b_pred: got %b%b want 11", is_branch_o, pred_taken_o); else passed++;
    exp_q.push_back(16'h10); exp_q.push_back(16'h10);
    repeat (2) begin
      tick(); e = exp_q.pop_front();
      total++; if (pc_o !== e) $display("FAIL b_self_loop: got %0h want %0h", pc_o, e); else passed++;
    end
    instr_i = 16'h20FC; #1;
    total++; if (pred_taken_o !== 1'b1) $display("FAIL b_bht_untouched: got %b want 1", pred_taken_o); else passed++;
    instr_i = 16'h0000;
    exp_q.push_back(16'h11);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL after_b: got %0h want %0h", pc_o, e); else passed++;
  endtask

  task automatic test_redirect_stall();
    stall_i = 1;
    jr_i = 1; jr_addr_i = 16'h40;
    exp_q.push_back(16'h11);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL stall_c1: got %0h want %0h", pc_o, e); else passed++;
    jr_i = 0;
    res_valid_i = 1; res_mispredict_i = 1; res_pc_i = 16'h20; res_taken_i = 0; res_target_i = 16'h99;
    #1;
    total++; if (epc_o !== 16'h20) $display("FAIL stall_mp_epc: got %0h want 20", epc_o); else passed++;
    exp_q.push_back(16'h11);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL stall_c2: got %0h want %0h", pc_o, e); else passed++;
    res_valid_i = 0; res_mispredict_i = 0;
    exp_q.push_back(16'h11);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL stall_c3: got %0h want %0h", pc_o, e); else passed++;
    stall_i = 0;
    exp_q.push_back(16'h21); exp_q.push_back(16'h22);
    repeat (2) begin
      tick(); e = exp_q.pop_front();
      total++; if (pc_o !== e) $display("FAIL pend_release: got %0h want %0h", pc_o, e); else passed++;
    end
    total++; if (stat_branches_o !== 32'd3 || stat_mispred_o !== 32'd1)
      $display("FAIL stats_after_stall: got %0d/%0d want 3/1", stat_branches_o, stat_mispred_o); else passed++;
  endtask

  task automatic test_back_to_back();
    jr_i = 1; jr_addr_i = 16'h80;
    res_valid_i = 1; res_mispredict_i = 1; res_pc_i = 16'h30; res_taken_i = 1; res_target_i = 16'h99;
    #1;
    total++; if (epc_o !== 16'h30) $display("FAIL both_epc: got %0h want 30", epc_o); else passed++;
    exp_q.push_back(16'h80);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL both_pc: got %0h want %0h", pc_o, e); else passed++;
    total++; if (stat_branches_o !== 32'd4 || stat_mispred_o !== 32'd2)
      $display("FAIL both_stats: got %0d/%0d want 4/2", stat_branches_o, stat_mispred_o); else passed++;
    jr_i = 0; res_pc_i = 16'h60; res_target_i = 16'h50; res_taken_i = 1;
    #1;
    total++; if (epc_o !== 16'h60) $display("FAIL mp_epc: got %0h want 60", epc_o); else passed++;
    exp_q.push_back(16'h50);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL mp_taken_pc: got %0h want %0h", pc_o, e); else passed++;
    clear_inputs();
    exp_q.push_back(16'h51);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL after_mp: got %0h want %0h", pc_o, e); else passed++;
    total++; if (epc_o !== 16'h51) $display("FAIL epc_default: got %0h want 51", epc_o); else passed++;
    total++; if (stat_branches_o !== 32'd5 || stat_mispred_o !== 32'd3)
      $display("FAIL mp_stats: got %0d/%0d want 5/3", stat_branches_o, stat_mispred_o); else passed++;
  endtask

  task automatic test_boot_redirect();
    RST = 1; #2; RST = 0;
    total++; if (pc_o !== 16'h0) $display("FAIL rerst_pc: got %0h want 0", pc_o); else passed++;
    jr_i = 1; jr_addr_i = 16'h33;
    exp_q.push_back(16'h0);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL boot_jr_hold: got %0h want %0h", pc_o, e); else passed++;
    jr_i = 0;
    exp_q.push_back(16'h33); exp_q.push_back(16'h34);
    repeat (2) begin
      tick(); e = exp_q.pop_front();
      total++; if (pc_o !== e) $display("FAIL boot_jr_release: got %0h want %0h", pc_o, e); else passed++;
    end
    stall_i = 1; jr_i = 1; jr_addr_i = 16'h44;
    exp_q.push_back(16'h34);
    tick(); e = exp_q.pop_front();
    total++; if (pc_o !== e) $display("FAIL rst_stall_hold: got %0h want %0h", pc_o, e); else passed++;
    jr_i = 0;
    RST = 1; #2; RST = 0;
    stall_i = 0;
    exp_q.push_back(16'h0); exp_q.push_back(16'h1); exp_q.push_back(16'h2);
    repeat (3) begin
      tick(); e = exp_q.pop_front();
      total++; if (pc_o !== e) $display("FAIL rst_discard_pend: got %0h want %0h", pc_o, e); else passed++;
    end
  endtask

  task automatic test_stat_saturate();
    RST = 1; #2; RST = 0;
    res_valid_i = 1; res_mispredict_i = 1; res_taken_i = 0; res_pc_i = 16'h70;
    repeat (18) tick();
    total++; if (sm4 !== 4'hF) $display("FAIL sat_mispred4: got %0h want f", sm4); else passed++;
    total++; if (sb4 !== 4'hF) $display("FAIL sat_branches4: got %0h want f", sb4); else passed++;
    total++; if (stat_mispred_o !== 32'd18) $display("FAIL mispred32: got %0d want 18", stat_mispred_o); else passed++;
    clear_inputs();
    RST = 1; #1;
    total++; if (sm4 !== 4'h0 || stat_mispred_o !== 32'd0)
      $display("FAIL sat_rst: got %0h/%0d want 0/0", sm4, stat_mispred_o); else passed++;
    RST = 0;
  endtask

  initial begin
    test_reset();
    test_branch_bht();
    test_uncond();
    test_redirect_stall();
    test_back_to_back();
    test_boot_redirect();
    test_stat_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
